// File: rtl/update_output_sparse_pkg.sv
// Shared types and the element keep rule for the sparse output-update stage.
// Build macro SPARSE_THRESH_EN selects the magnitude-threshold keep rule.
package update_output_pkg;

  localparam int DEF_IL = 4;
  localparam int DEF_FL = 16;
  localparam int KEEP_W = 64;

  typedef logic signed [DEF_IL+DEF_FL-1:0] fx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPACT = 2'b01,
    DONE    = 2'b10
  } state_t;

`ifdef SPARSE_THRESH_EN
  // One extra bit so negating the most-negative word cannot overflow.
  function automatic logic keep_elem(input logic signed [KEEP_W-1:0] x,
                                     input logic [KEEP_W-1:0] thresh);
    logic signed [KEEP_W:0] xe;
    logic [KEEP_W:0] mag;
    xe  = {x[KEEP_W-1], x};
    mag = xe[KEEP_W] ? -xe : xe;
    return mag > {1'b0, thresh};
  endfunction
`else
  function automatic logic keep_elem(input logic signed [KEEP_W-1:0] x);
    return x != '0;
  endfunction
`endif

endpackage

// File: rtl/update_output_sparse_if.sv
// Vector handshake bundle between producer, sparse update stage and consumer.
interface update_output_sparse_if #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int LANES = 16
);
  localparam int W  = IL + FL;
  localparam int CW = $clog2(LANES + 1);

  logic signed [W-1:0] i_im [LANES];
  logic                input_ready;
  logic                output_taken;
  logic signed [W-1:0] o_im [LANES];
  logic [LANES-1:0]    o_mask;
  logic [CW-1:0]       o_count;
  logic                o_valid;
  logic [1:0]          state;

  modport master (
    output i_im,
    output input_ready,
    output output_taken,
    input  o_im,
    input  o_mask,
    input  o_count,
    input  o_valid,
    input  state
  );

  modport slave (
    input  i_im,
    input  input_ready,
    input  output_taken,
    output o_im,
    output o_mask,
    output o_count,
    output o_valid,
    output state
  );
endinterface

// File: rtl/update_output_sparse_group_pack.sv
// Combinational keep/rank/count over one group of LPC words.
// Keep rule depends on build macro SPARSE_THRESH_EN.
module sparse_group_pack
  import update_output_pkg::*;
#(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int LPC    = 4,
  parameter int THRESH = 0,
  localparam int W     = IL + FL,
  localparam int RW    = $clog2(LPC + 1)
) (
  input  logic signed [W-1:0] grp_w [LPC],
  output logic [LPC-1:0]      keep,
  output logic [RW-1:0]       rank [LPC],
  output logic [RW-1:0]       cnt
);

  logic [RW-1:0] acc;

  always_comb begin
    keep = '0;
    acc  = '0;
    for (int k = 0; k < LPC; k++) begin
`ifdef SPARSE_THRESH_EN
      keep[k] = keep_elem(KEEP_W'(grp_w[k]), KEEP_W'(THRESH));
`else
      keep[k] = keep_elem(KEEP_W'(grp_w[k]));
`endif
      rank[k] = acc;
      acc     = acc + RW'(keep[k]);
    end
    cnt = acc;
  end

endmodule

// File: rtl/update_output_sparse.sv
// Compacts nonzero (or above-threshold with SPARSE_THRESH_EN) lanes of a
// vector into the low output slots, LPC lanes per cycle.
module update_output_sparse
  import update_output_pkg::*;
#(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int LANES  = 16,
  parameter int LPC    = 4,
  parameter int THRESH = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  update_output_sparse_if.slave bus
);

  localparam int W  = IL + FL;
  localparam int NG = LANES / LPC;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int CW = $clog2(LANES + 1);
  localparam int AW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW = $clog2(LPC + 1);

  state_t              state_q, state_d;
  logic                accept;
  logic                last_grp;

  logic signed [W-1:0] buf_q [LANES];
  logic signed [W-1:0] im_q  [LANES];
  logic [LANES-1:0]    mask_q;
  logic [GW-1:0]       grp_q;
  logic [CW-1:0]       wr_q;

  logic signed [W-1:0] grp_w [LPC];
  logic [LPC-1:0]      keep;
  logic [RW-1:0]       rank [LPC];
  logic [RW-1:0]       cnt;

  assign last_grp = (grp_q == GW'(NG - 1));

  always_comb begin
    for (int k = 0; k < LPC; k++) begin
      grp_w[k] = buf_q[AW'(int'(grp_q) * LPC + k)];
    end
  end

  sparse_group_pack #(
    .IL     (IL),
    .FL     (FL),
    .LPC    (LPC),
    .THRESH (THRESH)
  ) u_pack (
    .grp_w (grp_w),
    .keep  (keep),
    .rank  (rank),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.input_ready) begin
          accept  = 1'b1;
          state_d = COMPACT;
        end
      end
      COMPACT: begin
        if (last_grp) state_d = DONE;
      end
      DONE: begin
        if (bus.output_taken) begin
          if (bus.input_ready) begin
            accept  = 1'b1;
            state_d = COMPACT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept stage latches the vector; each COMPACT cycle scatters one group.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        buf_q[i] <= '0;
        im_q[i]  <= '0;
      end
      mask_q <= '0;
      grp_q  <= '0;
      wr_q   <= '0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        buf_q[i] <= bus.i_im[i];
        im_q[i]  <= '0;
      end
      mask_q <= '0;
      grp_q  <= '0;
      wr_q   <= '0;
    end else if (state_q == COMPACT) begin
      for (int k = 0; k < LPC; k++) begin
        if (keep[k]) begin
          im_q[AW'(int'(wr_q) + int'(rank[k]))] <= grp_w[k];
          mask_q[AW'(int'(grp_q) * LPC + k)]    <= 1'b1;
        end
      end
      wr_q  <= wr_q + CW'(cnt);
      grp_q <= last_grp ? '0 : grp_q + GW'(1);
    end
  end

  assign bus.o_im    = im_q;
  assign bus.o_mask  = mask_q;
  assign bus.o_count = wr_q;
  assign bus.o_valid = (state_q == DONE);
  assign bus.state   = state_q;

endmodule

// File: doc/update_output_sparse.md
Name: update_output_sparse

Overview:
Parametrised successor of the post-sparsity output-update stage. Accepts one LANES-wide vector of signed fixed-point activations and compacts its nonzero elements, in order, into the low slots of the output vector. Emits an occupancy mask and a count for the downstream sparse consumer. Compaction runs LPC lanes per cycle under an input_ready/output_taken handshake.

Parameters:
IL, 4, integer bits of the fixed-point word
FL, 16, fractional bits; word width W = IL+FL
LANES, 16, vector length; must be a multiple of LPC
LPC, 4, lanes scanned per COMPACT cycle
THRESH, 0, unsigned magnitude threshold (LSBs); used only with SPARSE_THRESH_EN

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low reset
i_im  in  W x LANES signed  input vector; sampled only on the accept edge
input_ready  in  1  producer has a valid vector
output_taken  in  1  consumer has taken o_im/o_mask/o_count
o_im  out  W x LANES signed  compacted vector; slots >= o_count are zero
o_mask  out  LANES  bit i = 1 iff i_im[i] was kept
o_count  out  $clog2(LANES+1)  number of kept elements
o_valid  out  1  outputs stable and valid (state == DONE)
state  out  2  FSM state: IDLE=00, COMPACT=01, DONE=10; 11 unreachable

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, o_im all 0, o_mask=0, o_count=0, o_valid=0, internal buffer, group index and write pointer cleared. Reset overrides every other input, including mid-COMPACT; the partial result is discarded.
- IDLE: if input_ready==1, latch i_im into buffer, clear o_im/o_mask/o_count, set grp=0 and wr=0, go to COMPACT. Otherwise hold.
- COMPACT: each cycle scan buffer lanes [grp*LPC, grp*LPC+LPC-1] in ascending order. Each kept element is written to o_im[wr+k], where k is its rank among kept elements in the group. The matching o_mask bit is set and wr advances by the group's kept count. o_count tracks wr. After group LANES/LPC-1, go to DONE. input_ready and output_taken are ignored.
- Latency: o_valid rises LANES/LPC edges after the accept edge (4 with defaults). Throughput is one vector per LANES/LPC+1 cycles; back-to-back operation gives LANES/LPC+1.
- DONE: o_valid=1 and outputs held. On output_taken==1:
  - with input_ready==0, go to IDLE, o_valid=0, outputs keep their values;
  - with input_ready==1, accept the new vector immediately as in IDLE and go to COMPACT.
- Keep rule without the macro: element kept iff it is not equal to 0. The full W-bit compare is used, so negative values are kept.
- All-zero vector: o_count=0, o_mask=0, o_im all 0, DONE still reached.
- Fully dense vector: o_count=LANES, o_im equals the input, o_mask all ones. wr never exceeds LANES.
- Values are passed through unmodified; no arithmetic on data.

Optional Feature:
SPARSE_THRESH_EN: when defined, an element is kept iff |x| > THRESH. |x| is computed in W+1 bits so the most-negative value does not overflow. When undefined, the keep rule is x != 0 and THRESH is unused.

Decomposition:
- Package update_output_pkg holds:
  - typedef fx_t, signed [IL+FL-1:0];
  - enum state_t {IDLE=2'b00, COMPACT=2'b01, DONE=2'b10};
  - the keep-function helper.
- One natural sub-module, sparse_group_pack: combinational, takes LPC words plus THRESH. It outputs a keep bitmap, a per-element prefix rank and the group kept count. It is instantiated once per cycle on the selected group.

Test Plan:
- Defaults; i_im[j]=j+1 with lanes 5,7,8,11,15 zeroed; input_ready pulsed one cycle. Expected: o_valid after 4 cycles; o_count=11; o_mask=16'h765F; o_im=1,2,3,4,5,7,10,11,13,14,15 then five zeros.
- All-zero input. Expected: DONE in 4 cycles, o_count=0, o_mask=0, o_im all zero. Then all-ones input (value 1 in every lane): o_count=16, o_mask=16'hFFFF.
- Hold output_taken=0 for 20 cycles in DONE while toggling input_ready. Expected: state stays 10 and outputs unchanged. Then assert output_taken with input_ready=1: next state 01 and the new vector is captured.
- Assert reset=0 during the 2nd COMPACT cycle. Expected: next edge state=00, o_valid=0, o_count=0, o_mask=0. A fresh vector then completes correctly.
- Negative values -1 and the most-negative value in lanes 0 and 15, rest zero. Expected: o_count=2, o_im[0]=-1, o_im[1]=most-negative, o_mask=16'h8001.
- With SPARSE_THRESH_EN and THRESH=3, input 1..16 with no zeros. Expected: o_count=13, o_mask=16'hFFF8, o_im[0]=4.
